ime_partition_cost_collector: RTL

Accumulates per-candidate quadrant SADs from the IME SAD tree over one search pass. Keeps the running minimum cost (and the matching MV) for each of the nine partition shapes of the current block. On completion it presents the nine costs to the partition decision engine as a stable, registered bundle. It sits between the IME SAD tree / MV-cost unit (upstream) and the partition decision engine (downstream).

---
 rtl/ime_partition_cost_collector.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ime_partition_cost_collector.sv
// ime_partition_cost_collector: running per-shape minimum cost/MV over one IME search pass.
// Optional feature macro: IME_COST_MV_TRACK_EN (MV tracking); cost width macro: IME_COST_WIDTH.
`ifndef IME_COST_WIDTH
`define IME_COST_WIDTH 16
`endif

module ime_partition_cost_collector #(
   parameter int unsigned SAD_WIDTH = 16,
   parameter int unsigned MVC_WIDTH = 12,
   parameter int unsigned MV_WIDTH  = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_i,
   input  logic                        val_i,
   input  logic                        last_i,
   input  logic [SAD_WIDTH-1:0]        sad_q0_i,
   input  logic [SAD_WIDTH-1:0]        sad_q1_i,
   input  logic [SAD_WIDTH-1:0]        sad_q2_i,
   input  logic [SAD_WIDTH-1:0]        sad_q3_i,
   input  logic [MVC_WIDTH-1:0]        mvc_i,
   input  logic [MV_WIDTH-1:0]         mv_x_i,
   input  logic [MV_WIDTH-1:0]         mv_y_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_1nx1n_cst_0_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_1nx1n_cst_1_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_1nx1n_cst_2_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_1nx1n_cst_3_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_1nx2n_cst_0_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_1nx2n_cst_1_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_2nx1n_cst_0_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_2nx1n_cst_1_o,
   output logic [`IME_COST_WIDTH-1:0]  dat_2nx2n_cst_o,
   output logic [MV_WIDTH-1:0]         mv_1nx1n_0_x_o,
   output logic [MV_WIDTH-1:0]         mv_1nx1n_0_y_o,
   output logic [MV_WIDTH-1:0]         mv_1nx1n_1_x_o,
   output logic [MV_WIDTH-1:0]         mv_1nx1n_1_y_o,
   output logic [MV_WIDTH-1:0]         mv_1nx1n_2_x_o,
   output logic [MV_WIDTH-1:0]         mv_1nx1n_2_y_o,
   output logic [MV_WIDTH-1:0]         mv_1nx1n_3_x_o,
   output logic [MV_WIDTH-1:0]         mv_1nx1n_3_y_o,
   output logic [MV_WIDTH-1:0]         mv_1nx2n_0_x_o,
   output logic [MV_WIDTH-1:0]         mv_1nx2n_0_y_o,
   output logic [MV_WIDTH-1:0]         mv_1nx2n_1_x_o,
   output logic [MV_WIDTH-1:0]         mv_1nx2n_1_y_o,
   output logic [MV_WIDTH-1:0]         mv_2nx1n_0_x_o,
   output logic [MV_WIDTH-1:0]         mv_2nx1n_0_y_o,
   output logic [MV_WIDTH-1:0]         mv_2nx1n_1_x_o,
   output logic [MV_WIDTH-1:0]         mv_2nx1n_1_y_o,
   output logic [MV_WIDTH-1:0]         mv_2nx2n_x_o,
   output logic [MV_WIDTH-1:0]         mv_2nx2n_y_o,
   output logic [15:0]                 cand_cnt_o
);

   localparam int unsigned COST_W  = `IME_COST_WIDTH;
   localparam int unsigned NUM_SHP = 9;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned SUM_W   = ((SAD_WIDTH + 2 > MVC_WIDTH) ? SAD_WIDTH + 2 : MVC_WIDTH) + 1;
   localparam int unsigned EXT_W   = (SUM_W > COST_W) ? SUM_W : COST_W;

   typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_FLUSH, ST_DONE} state_e;

   state_e             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               s1_vld_q, s1_vld_d;
   logic               s1_last_q, s1_last_d;
   logic [COST_W-1:0]  s1_cost_q [NUM_SHP];
   logic [COST_W-1:0]  s1_cost_d [NUM_SHP];
   logic [COST_W-1:0]  min_q [NUM_SHP];
   logic [COST_W-1:0]  min_d [NUM_SHP];
   logic [SUM_W-1:0]   sum_c [NUM_SHP];
   logic [SUM_W-1:0]   q0_c, q1_c, q2_c, q3_c, mvc_c;
   logic [NUM_SHP-1:0] upd_c;
   logic               accept_c;
   logic [MV_WIDTH-1:0] mvx_out_c [NUM_SHP];
   logic [MV_WIDTH-1:0] mvy_out_c [NUM_SHP];

   // Clamp a wide sum to the cost width without wraparound
   function automatic logic [COST_W-1:0] sat_cost(input logic [SUM_W-1:0] s);
      logic [EXT_W-1:0] e;
      e = EXT_W'(s);
      if (e > EXT_W'({COST_W{1'b1}})) sat_cost = '1;
      else                            sat_cost = COST_W'(e);
   endfunction

   // Nine shape sums from the four quadrants plus MV cost
   always_comb begin
      q0_c     = SUM_W'(sad_q0_i);
      q1_c     = SUM_W'(sad_q1_i);
      q2_c     = SUM_W'(sad_q2_i);
      q3_c     = SUM_W'(sad_q3_i);
      mvc_c    = SUM_W'(mvc_i);
      sum_c[0] = q0_c + mvc_c;
      sum_c[1] = q1_c + mvc_c;
      sum_c[2] = q2_c + mvc_c;
      sum_c[3] = q3_c + mvc_c;
      sum_c[4] = q0_c + q2_c + mvc_c;
      sum_c[5] = q1_c + q3_c + mvc_c;
      sum_c[6] = q0_c + q1_c + mvc_c;
      sum_c[7] = q2_c + q3_c + mvc_c;
      sum_c[8] = q0_c + q1_c + q2_c + q3_c + mvc_c;
   end

   // Pass control, stage-1 capture and stage-2 minimum tracking
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      accept_c  = val_i & (start_i | (state_q == ST_SEARCH));
      s1_vld_d  = accept_c;
      s1_last_d = accept_c & last_i;
      for (int k = 0; k < NUM_SHP; k++) begin
         s1_cost_d[k] = sat_cost(sum_c[k]);
         // a start discards whatever is still in stage 1
         upd_c[k]     = s1_vld_q & ~start_i & (s1_cost_q[k] < min_q[k]);
         min_d[k]     = start_i ? '1 : (upd_c[k] ? s1_cost_q[k] : min_q[k]);
      end
      if (accept_c && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
         ST_IDLE:   state_d = ST_IDLE;
         ST_SEARCH: if (accept_c && last_i) state_d = ST_FLUSH;
         ST_FLUSH: begin
            if (s1_vld_q && s1_last_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (start_i) begin
         state_d = (val_i && last_i) ? ST_FLUSH : ST_SEARCH;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         cnt_d   = CNT_W'(val_i);
      end
   end

   // State, pipeline and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         for (int k = 0; k < NUM_SHP; k++) begin
            s1_cost_q[k] <= '0;
            min_q[k]     <= '1;
         end
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
         s1_vld_q  <= s1_vld_d;
         s1_last_q <= s1_last_d;
         for (int k = 0; k < NUM_SHP; k++) begin
            s1_cost_q[k] <= s1_cost_d[k];
            min_q[k]     <= min_d[k];
         end
      end
   end

`ifdef IME_COST_MV_TRACK_EN
   logic [MV_WIDTH-1:0] s1_mvx_q, s1_mvx_d, s1_mvy_q, s1_mvy_d;
   logic [MV_WIDTH-1:0] mvx_q [NUM_SHP];
   logic [MV_WIDTH-1:0] mvx_d [NUM_SHP];
   logic [MV_WIDTH-1:0] mvy_q [NUM_SHP];
   logic [MV_WIDTH-1:0] mvy_d [NUM_SHP];

   // MV follows the cost update of its shape
   always_comb begin
      s1_mvx_d = mv_x_i;
      s1_mvy_d = mv_y_i;
      for (int k = 0; k < NUM_SHP; k++) begin
         mvx_d[k]     = start_i ? '0 : (upd_c[k] ? s1_mvx_q : mvx_q[k]);
         mvy_d[k]     = start_i ? '0 : (upd_c[k] ? s1_mvy_q : mvy_q[k]);
         mvx_out_c[k] = mvx_q[k];
         mvy_out_c[k] = mvy_q[k];
      end
   end

   // MV pipeline and best-MV registers
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_mvx_q <= '0;
         s1_mvy_q <= '0;
         for (int k = 0; k < NUM_SHP; k++) begin
            mvx_q[k] <= '0;
            mvy_q[k] <= '0;
         end
      end else begin
         s1_mvx_q <= s1_mvx_d;
         s1_mvy_q <= s1_mvy_d;
         for (int k = 0; k < NUM_SHP; k++) begin
            mvx_q[k] <= mvx_d[k];
            mvy_q[k] <= mvy_d[k];
         end
      end
   end
`else
   logic unused_mv;
   assign unused_mv = ^{mv_x_i, mv_y_i};

   // MV tracking removed: MV outputs are constant zero
   always_comb begin
      for (int k = 0; k < NUM_SHP; k++) begin
         mvx_out_c[k] = '0;
         mvy_out_c[k] = '0;
      end
   end
`endif

   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign cand_cnt_o        = cnt_q;
   assign dat_1nx1n_cst_0_o = min_q[0];
   assign dat_1nx1n_cst_1_o = min_q[1];
   assign dat_1nx1n_cst_2_o = min_q[2];
   assign dat_1nx1n_cst_3_o = min_q[3];
   assign dat_1nx2n_cst_0_o = min_q[4];
   assign dat_1nx2n_cst_1_o = min_q[5];
   assign dat_2nx1n_cst_0_o = min_q[6];
   assign dat_2nx1n_cst_1_o = min_q[7];
   assign dat_2nx2n_cst_o   = min_q[8];
   assign mv_1nx1n_0_x_o    = mvx_out_c[0];
   assign mv_1nx1n_0_y_o    = mvy_out_c[0];
   assign mv_1nx1n_1_x_o    = mvx_out_c[1];
   assign mv_1nx1n_1_y_o    = mvy_out_c[1];
   assign mv_1nx1n_2_x_o    = mvx_out_c[2];
   assign mv_1nx1n_2_y_o    = mvy_out_c[2];
   assign mv_1nx1n_3_x_o    = mvx_out_c[3];
   assign mv_1nx1n_3_y_o    = mvy_out_c[3];
   assign mv_1nx2n_0_x_o    = mvx_out_c[4];
   assign mv_1nx2n_0_y_o    = mvy_out_c[4];
   assign mv_1nx2n_1_x_o    = mvx_out_c[5];
   assign mv_1nx2n_1_y_o    = mvy_out_c[5];
   assign mv_2nx1n_0_x_o    = mvx_out_c[6];
   assign mv_2nx1n_0_y_o    = mvy_out_c[6];
   assign mv_2nx1n_1_x_o    = mvx_out_c[7];
   assign mv_2nx1n_1_y_o    = mvy_out_c[7];
   assign mv_2nx2n_x_o      = mvx_out_c[8];
   assign mv_2nx2n_y_o      = mvy_out_c[8];

endmodule
